// File: rtl/sqrt_arbiter_if.sv
// Channel request/response bus plus the link to the shared sqrt core.
// The arbiter takes the slave view; the channels/core side take the master view.
interface sqrt_arbiter_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]    req_valid_i;
   logic [N_REQ*40-1:0] req_data_i;
   logic [N_REQ-1:0]    req_ready_o;
   logic [N_REQ-1:0]    rsp_valid_o;
   logic [15:0]         rsp_data_o;
   logic                rsp_err_o;
   logic                sq_start_o;
   logic [39:0]         sq_a_o;
   logic                sq_valid_i;
   logic [15:0]         sq_result_i;

   modport slave (
      input  req_valid_i,
      input  req_data_i,
      output req_ready_o,
      output rsp_valid_o,
      output rsp_data_o,
      output rsp_err_o,
      output sq_start_o,
      output sq_a_o,
      input  sq_valid_i,
      input  sq_result_i
   );

   modport master (
      output req_valid_i,
      output req_data_i,
      input  req_ready_o,
      input  rsp_valid_o,
      input  rsp_data_o,
      input  rsp_err_o,
      input  sq_start_o,
      input  sq_a_o,
      output sq_valid_i,
      output sq_result_i
   );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one sqrt core among N_REQ channels.
// One transaction at a time: accept, pulse start, wait for the core (with a
// watchdog), then return the result to the owning channel for one cycle.
module sqrt_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   sqrt_arbiter_if.slave bus,
   output logic          busy_o,
   output logic [7:0]    err_cnt_o
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] idx_q, idx_d;
   logic [39:0]      a_q, a_d;
   logic [15:0]      res_q, res_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   logic [PTR_W-1:0] winner;
   logic             found;
   logic [39:0]      req_slice [N_REQ];

   // Channel index base+off folded back into 0..N_REQ-1.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return PTR_W'(sum);
   endfunction

   // Per-channel views of the packed operand bus and one-hot decodes.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
      assign req_slice[gi]          = bus.req_data_i[gi*40 +: 40];
      assign bus.req_ready_o[gi]    = (state_q == ST_IDLE) && found && (winner == PTR_W'(gi));
      assign bus.rsp_valid_o[gi]    = (state_q == ST_DONE) && (idx_q == PTR_W'(gi));
   end

   // Round-robin pick: first valid channel at or after ptr_q, wrapping.
   // Scanning from the farthest offset down lets the nearest one win.
   always_comb begin
      found  = |bus.req_valid_i;
      winner = ptr_q;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid_i[wrap_add(ptr_q, i)]) winner = wrap_add(ptr_q, i);
      end
   end

   // Next-state and datapath updates for the sequencer.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      a_d       = a_q;
      res_d     = res_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      timer_d   = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               a_d     = req_slice[winner];
               idx_d   = winner;
               ptr_d   = (winner == PTR_LAST) ? '0 : winner + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + 1'b1;
            // A result arriving on the last allowed cycle still beats the watchdog.
            if (bus.sq_valid_i) begin
               res_d   = bus.sq_result_i;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end else if (timer_q == TMR_LAST) begin
               res_d   = '0;
               err_d   = 1'b1;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         a_q       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         res_q     <= res_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         timer_q   <= timer_d;
      end
   end

   assign bus.sq_start_o = (state_q == ST_ISSUE);
   assign bus.sq_a_o     = a_q;
   assign bus.rsp_data_o = res_q;
   assign bus.rsp_err_o  = (state_q == ST_DONE) && err_q;
   assign busy_o         = (state_q != ST_IDLE);
   assign err_cnt_o      = err_cnt_q;

endmodule
